// File: rtl/riscv_i32_trace_buffer.sv
// Compressed retirement-trace capture: folds sequential retires into a count and
// writes only control-flow discontinuities into a small FIFO drained by the debug module.
module riscv_i32_trace_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   riscv_clk_enable,
    input  logic                   trace__instr_valid,
    input  logic [2:0]             trace__mode,
    input  logic [31:0]            trace__instr_pc,
    input  logic                   trace__branch_taken,
    input  logic [31:0]            trace__branch_target,
    input  logic                   trace__trap,
    input  logic                   trace__ret,
    input  logic                   trace__jalr,
    input  logic                   trace__bkpt_valid,
    input  logic                   cfg_enable,
    input  logic [7:0]             cfg_mode_mask,
    input  logic                   cfg_stop_on_bkpt,
    input  logic                   ctl_clear,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [1:0]             rd_kind,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic [31:0]            rd_addr,
    output logic [DEPTH_LOG2:0]    occupancy,
    output logic                   overflow,
    output logic [1:0]             state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [COUNT_WIDTH-1:0] CMAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] SEQ_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CMAX_M1  = CMAX - SEQ_ONE;
    localparam logic [DEPTH_LOG2:0]    FULL_OCC = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]    OCC_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] K_SYNC   = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_TRAP   = 2'd2;
    localparam logic [1:0] K_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_RUN     = 2'd2,
        ST_STOPPED = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]             kind;
        logic [COUNT_WIDTH-1:0] count;
        logic [31:0]            addr;
    } entry_t;

    entry_t                  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     occ_q, occ_d;
    logic                    ovf_q;
    logic [COUNT_WIDTH-1:0]  seq_q, seq_d;
    state_e                  state_q, state_d;

    logic   qual, unqual, bkpt_stop, full, pop;
    logic   wr_req, wr_drop, wr_do;
    entry_t wr_entry, head;

    assign qual      = riscv_clk_enable & trace__instr_valid &  cfg_mode_mask[trace__mode];
    assign unqual    = riscv_clk_enable & trace__instr_valid & ~cfg_mode_mask[trace__mode];
    assign bkpt_stop = riscv_clk_enable & trace__bkpt_valid & cfg_stop_on_bkpt;
    assign full      = (occ_q == FULL_OCC);
    assign rd_valid  = (occ_q != '0);
    assign pop       = rd_valid & rd_ready;
    assign wr_do     = wr_req & ~wr_drop;

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        wr_req   = 1'b0;
        wr_drop  = 1'b0;
        wr_entry = '0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (qual) begin
                    wr_req   = 1'b1;
                    wr_entry = '{kind: K_SYNC, count: '0, addr: trace__instr_pc};
                    seq_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    // Disable wins over any same-cycle retire; pending count loses its PC.
                    if (seq_q != '0) begin
                        wr_req   = 1'b1;
                        wr_entry = '{kind: K_COUNT, count: seq_q, addr: 32'h0};
                    end
                    seq_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    if (qual) begin
                        if (trace__trap || trace__ret) begin
                            wr_req   = 1'b1;
                            wr_entry = '{kind: K_TRAP, count: seq_q + SEQ_ONE, addr: trace__branch_target};
                            seq_d    = '0;
                        end else if (trace__branch_taken || trace__jalr) begin
                            wr_req   = 1'b1;
                            wr_entry = '{kind: K_BRANCH, count: seq_q + SEQ_ONE, addr: trace__branch_target};
                            seq_d    = '0;
                        end else if (seq_q == CMAX_M1) begin
                            wr_req   = 1'b1;
                            wr_entry = '{kind: K_COUNT, count: CMAX, addr: trace__instr_pc};
                            seq_d    = '0;
                        end else begin
                            seq_d = seq_q + SEQ_ONE;
                        end
                    end else if (unqual) begin
                        if (seq_q != '0) begin
                            wr_req   = 1'b1;
                            wr_entry = '{kind: K_COUNT, count: seq_q, addr: trace__instr_pc};
                        end
                        seq_d   = '0;
                        state_d = ST_SYNC;
                    end
                    // Breakpoint flushes whatever count survived this cycle's retire.
                    if (bkpt_stop) begin
                        if (!wr_req && seq_d != '0) begin
                            wr_req   = 1'b1;
                            wr_entry = '{kind: K_COUNT, count: seq_d, addr: trace__instr_pc};
                        end
                        seq_d   = '0;
                        state_d = ST_STOPPED;
                    end
                end
            end
            ST_STOPPED: begin
                if (!cfg_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A dropped entry breaks the trace, so force a resync once space frees up.
        wr_drop = wr_req & full & ~pop;
        if (wr_drop) begin
            seq_d   = '0;
            state_d = ST_SYNC;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (wr_do && !pop)      occ_d = occ_q + OCC_ONE;
        else if (!wr_do && pop) occ_d = occ_q - OCC_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
            state_q  <= ST_IDLE;
        end else if (ctl_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
            state_q  <= cfg_enable ? ST_SYNC : ST_IDLE;
        end else begin
            if (wr_do) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (wr_drop) ovf_q <= 1'b1;
            occ_q   <= occ_d;
            seq_q   <= seq_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do && !ctl_clear) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head      = mem_q[rd_ptr_q];
    assign rd_kind   = rd_valid ? head.kind  : '0;
    assign rd_count  = rd_valid ? head.count : '0;
    assign rd_addr   = rd_valid ? head.addr  : '0;
    assign occupancy = occ_q;
    assign overflow  = ovf_q;
    assign state     = state_q;

endmodule
